dtm_pipe_mac: RTL
=================

// Module: dtm_pipe_mac
// PURPOSE
//  Pipelined, parametrised successor of the combinational dynamic truncated multiplier.
//  - Signed radix-4 Booth multiply of a*b; returns the upper BITWIDTH bits.
//  - Mode is selectable per transaction: exact, or approximate with column truncation.
//  - Optional running accumulation for DNN dot products.
//  - Sits between the activation/weight fetch and the layer output buffer.
//  - valid/ready on both sides.
// PARAMETERS
//  BITWIDTH     8         operand and result width; even, 4..16
//  TRUNC_COLS   BITWIDTH  approx mode drops PP columns < TRUNC_COLS; 0..2*BITWIDTH-1
//  PIPE_STAGES  2         register stages from input to output, 1..3; latency = PIPE_STAGES
//  ACC_WIDTH    2*BITWIDTH  accumulator width; >= BITWIDTH+4
//  TAG_WIDTH    4         opaque sideband carried with each transaction
// PORTS
//  clk          in   1          rising-edge clock
//  rst_n        in   1          asynchronous active-low reset
//  in_valid     in   1          input transaction present
//  in_ready     out  1          block accepts input this cycle
//  in_a         in   BITWIDTH   multiplicand, two's complement
//  in_b         in   BITWIDTH   multiplier, two's complement
//  in_approx    in   1          1 = truncated approximate mode, 0 = exact mode
//  in_acc_first in   1          1 = this product restarts the accumulator
//  in_tag       in   TAG_WIDTH  sideband, returned unchanged
//  out_valid    out  1          output transaction present
//  out_ready    in   1          downstream accepts output
//  out_r        out  BITWIDTH   upper product bits (see arithmetic)
//  out_acc      out  ACC_WIDTH  accumulator value including this out_r
//  out_tag      out  TAG_WIDTH  tag of this transaction
// BEHAVIOUR
//  Reset (async assert, sync deassert by clk)
//  - All stage valid bits = 0; accumulator = 0.
//  - out_valid = 0; out_r, out_acc, out_tag = 0; in_ready = 1 after reset.
//  Handshake
//  - Transfer occurs when valid & ready in the same cycle.
//  - out_valid/out_r/out_acc/out_tag hold stable while out_valid & !out_ready.
//  - in_ready = !v[last] | out_ready (combinational, global stall). Stalled stages hold their contents.
//  - Bubbles: while not stalled, an empty stage is overwritten by its predecessor.
//    No bubble squeezing is required beyond this rule.
//  - Full throughput: one transfer per cycle when out_ready = 1.
//  Latency and order
//  - Input accepted at cycle t appears with out_valid at t+PIPE_STAGES if never stalled.
//  - Strictly in order.
//  - in_approx, in_acc_first and in_tag travel with their own transaction.
//    Mode changes take effect per transaction, never per cycle.
//  Arithmetic (P = signed 2*BITWIDTH product)
//  - Exact: out_r = P[2*BITWIDTH-1:BITWIDTH].
//  - Approx:
//    - Form BITWIDTH/2 Booth radix-4 partial-product rows, plus their +1 negation-correction bits.
//    - Discard every bit in column < TRUNC_COLS.
//    - Sum the rest modulo 2^(2*BITWIDTH); out_r = bits [2*BITWIDTH-1:BITWIDTH].
//    - TRUNC_COLS = 0 must equal exact mode.
//  - Accumulator: acc_next = (acc_first ? 0 : acc) + sign_extend(out_r).
//    - Wraps modulo 2^ACC_WIDTH; no saturation.
//    - Updated only on the output transfer cycle; out_acc shows acc_next.
//  Boundary conditions
//  - Corner operands must be correct in both modes: a = b = -2^(BITWIDTH-1), and operands of 0.
//  - out_ready = 0 with the pipe full: in_ready = 0, no data lost or duplicated.
//  - Same-cycle in_valid & out_ready with the pipe full: accept and emit in the same cycle.
//  - Reset asserted mid-stream: all in-flight transactions are discarded and none emerge afterwards.
// TESTING
//  - Exact, BITWIDTH = 8:
//    - a = 0x7F, b = 0x7F -> out_r = 0x3F.
//    - a = 0x80, b = 0x80 -> 0x40.
//    - a = 0x80, b = 0x7F -> 0xC0.
//  - Approx, TRUNC_COLS = 8, random 10k vectors vs the Booth column model.
//    - Bit exact; TRUNC_COLS = 0 run equals exact mode.
//  - Latency: single transaction, PIPE_STAGES = 2, accepted at cycle 5 -> out_valid at cycle 7, one cycle wide.
//  - Backpressure:
//    - Stream tags 0..15 with random out_ready (50%).
//    - Outputs are tags 0..15 in order, none lost or duplicated, and stable while stalled.
//  - Accumulate:
//    - Products 0x3F, 0x40, 0xC0 (first flag on the first one) -> out_acc = 0x003F, 0x007F, 0x003F.
//    - Next first flag restarts from out_r.
//  - Reset with three in flight: rst_n low 1 cycle -> out_valid stays 0; the next input gets the correct result.

Source files
------------

// File: rtl/dtm_pipe_mac.sv
// Pipelined signed radix-4 Booth multiplier (exact or column-truncated) with running accumulator.
// Latency: PIPE_STAGES cycles from input transfer to out_valid; one transfer per cycle when unstalled.
// Backpressure: global stall when the last stage holds data and out_ready is low; in_ready = !v[last] | out_ready.
module dtm_pipe_mac #(
    parameter int BITWIDTH    = 8,
    parameter int TRUNC_COLS  = BITWIDTH,
    parameter int PIPE_STAGES = 2,
    parameter int ACC_WIDTH   = 2*BITWIDTH,
    parameter int TAG_WIDTH   = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [BITWIDTH-1:0]  in_a,
    input  logic [BITWIDTH-1:0]  in_b,
    input  logic                 in_approx,
    input  logic                 in_acc_first,
    input  logic [TAG_WIDTH-1:0] in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [BITWIDTH-1:0]  out_r,
    output logic [ACC_WIDTH-1:0] out_acc,
    output logic [TAG_WIDTH-1:0] out_tag
);

    localparam int PW    = 2*BITWIDTH;
    localparam int NROWS = BITWIDTH/2;
    localparam int LAST  = PIPE_STAGES-1;

    // Columns kept in approximate mode; exact mode keeps every column so the
    // same Booth array serves both modes (TRUNC_COLS = 0 is then exact by construction).
    localparam logic [PW-1:0] KEEP_APPROX = {PW{1'b1}} << TRUNC_COLS;

    // Per-transaction payload that travels down the pipe.
    typedef struct packed {
        logic [BITWIDTH-1:0]  r;
        logic                 first;
        logic [TAG_WIDTH-1:0] tag;
    } stage_t;

    logic [PW-1:0]         a_ext;
    logic [BITWIDTH:0]     b_pad;
    logic [PW-1:0]         keep;
    logic [PW-1:0]         sum_d;
    logic [PW-1:0]         mag;
    logic [PW-1:0]         row;
    logic [PW-1:0]         corr;
    logic [2:0]            trip;
    logic                  neg;

    stage_t                stage_d;
    stage_t                d_q [PIPE_STAGES];
    logic [PIPE_STAGES-1:0] v_q;
    logic [ACC_WIDTH-1:0]  acc_q;
    logic [ACC_WIDTH-1:0]  acc_base;
    logic [ACC_WIDTH-1:0]  acc_d;
    logic                  stall;

    assign a_ext = {{BITWIDTH{in_a[BITWIDTH-1]}}, in_a};
    assign b_pad = {in_b, 1'b0};
    assign keep  = in_approx ? KEEP_APPROX : {PW{1'b1}};

    // Booth radix-4 rows: negative digits use one's complement plus a +1 bit in the row's LSB column;
    // both the row bits and the correction bit are masked by the kept-column set before summing.
    always_comb begin
        sum_d = '0;
        mag   = '0;
        row   = '0;
        corr  = '0;
        trip  = '0;
        neg   = 1'b0;
        for (int i = 0; i < NROWS; i++) begin
            trip = b_pad[2*i +: 3];
            case (trip)
                3'b001, 3'b010: begin mag = a_ext;      neg = 1'b0; end
                3'b011:         begin mag = a_ext << 1; neg = 1'b0; end
                3'b100:         begin mag = a_ext << 1; neg = 1'b1; end
                3'b101, 3'b110: begin mag = a_ext;      neg = 1'b1; end
                default:        begin mag = '0;         neg = 1'b0; end
            endcase
            row   = (neg ? ~mag : mag) << (2*i);
            corr  = {{(PW-1){1'b0}}, neg} << (2*i);
            sum_d = sum_d + (row & keep) + (corr & keep);
        end
    end

    assign stage_d.r     = sum_d[PW-1:BITWIDTH];
    assign stage_d.first = in_acc_first;
    assign stage_d.tag   = in_tag;

    assign stall    = v_q[LAST] & ~out_ready;
    assign in_ready = ~stall;

    // Pipe registers: whole pipe advances together unless the output is blocked.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= '0;
            for (int k = 0; k < PIPE_STAGES; k++) begin
                d_q[k] <= '0;
            end
        end else if (!stall) begin
            v_q[0] <= in_valid;
            if (in_valid) begin
                d_q[0] <= stage_d;
            end
            for (int k = 1; k < PIPE_STAGES; k++) begin
                v_q[k] <= v_q[k-1];
                if (v_q[k-1]) begin
                    d_q[k] <= d_q[k-1];
                end
            end
        end
    end

    // Accumulator view of the head transaction; committed only when it transfers out.
    assign acc_base = d_q[LAST].first ? '0 : acc_q;
    assign acc_d    = acc_base + {{(ACC_WIDTH-BITWIDTH){d_q[LAST].r[BITWIDTH-1]}}, d_q[LAST].r};

    // Accumulator register, wraps modulo 2^ACC_WIDTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else if (v_q[LAST] && out_ready) begin
            acc_q <= acc_d;
        end
    end

    assign out_valid = v_q[LAST];
    assign out_r     = d_q[LAST].r;
    assign out_tag   = d_q[LAST].tag;
    assign out_acc   = acc_d;

endmodule
